// File: rtl/jtag_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_pkg
// Description : Shared TAP state encoding, IDCODE width and BYPASS opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_tap_pkg;

    localparam int unsigned c_idcode_width = 32;

    // Encoding follows the customary 1149.1 numbering so state_o matches lab tools
    typedef enum logic [3:0] {
        ST_EXIT2_DR  = 4'h0,
        ST_EXIT1_DR  = 4'h1,
        ST_SHIFT_DR  = 4'h2,
        ST_PAUSE_DR  = 4'h3,
        ST_SEL_IR    = 4'h4,
        ST_UPDATE_DR = 4'h5,
        ST_CAP_DR    = 4'h6,
        ST_SEL_DR    = 4'h7,
        ST_EXIT2_IR  = 4'h8,
        ST_EXIT1_IR  = 4'h9,
        ST_SHIFT_IR  = 4'hA,
        ST_PAUSE_IR  = 4'hB,
        ST_RTI       = 4'hC,
        ST_UPDATE_IR = 4'hD,
        ST_CAP_IR    = 4'hE,
        ST_TLR       = 4'hF
    } tap_state_e;

    function automatic int unsigned bypass_opcode(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_multi_if
// Description : JTAG pin and user-chain signal bundle for jtag_tap_multi.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_tap_multi_if
    import jtag_tap_pkg::*;
#(
    parameter int IR_WIDTH    = 5,
    parameter int NUM_USER_DR = 2
);
    logic                   tms_i;
    logic                   td_i;
    logic                   td_o;
    logic                   tdo_oe_o;
    logic [IR_WIDTH-1:0]    ir_o;
    logic [NUM_USER_DR-1:0] dr_sel_o;
    logic                   capture_dr_o;
    logic                   shift_dr_o;
    logic                   update_dr_o;
    logic [NUM_USER_DR-1:0] user_tdo_i;
    tap_state_e             state_o;

    modport master (
        output tms_i, td_i, user_tdo_i,
        input  td_o, tdo_oe_o, ir_o, dr_sel_o, capture_dr_o, shift_dr_o,
               update_dr_o, state_o
    );

    modport slave (
        input  tms_i, td_i, user_tdo_i,
        output td_o, tdo_oe_o, ir_o, dr_sel_o, capture_dr_o, shift_dr_o,
               update_dr_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : 16-state TAP controller state register and next-state logic.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  wire logic tck_i,
    input  wire logic trst_i,
    input  wire logic tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:       state_d = tms_i ? ST_TLR       : ST_RTI;
            ST_RTI:       state_d = tms_i ? ST_SEL_DR    : ST_RTI;
            ST_SEL_DR:    state_d = tms_i ? ST_SEL_IR    : ST_CAP_DR;
            ST_CAP_DR:    state_d = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:  state_d = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:  state_d = tms_i ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:  state_d = tms_i ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:  state_d = tms_i ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR: state_d = tms_i ? ST_SEL_DR    : ST_RTI;
            ST_SEL_IR:    state_d = tms_i ? ST_TLR       : ST_CAP_IR;
            ST_CAP_IR:    state_d = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:  state_d = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:  state_d = tms_i ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:  state_d = tms_i ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:  state_d = tms_i ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR: state_d = tms_i ? ST_SEL_DR    : ST_RTI;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_multi
// Description : Parametrised TAP with IR, IDCODE/BYPASS DRs and user chains.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_multi
    import jtag_tap_pkg::*;
#(
    parameter int                        IR_WIDTH     = 5,
    parameter int                        NUM_USER_DR  = 2,
    parameter int unsigned               USER_IR_BASE = 'h10,
    parameter logic [c_idcode_width-1:0] IDCODE_VAL   = 32'h10E3_1913,
    parameter int unsigned               IDCODE_IR    = 'h01
) (
    input  wire logic        tck_i,
    input  wire logic        trst_i,
    jtag_tap_multi_if.slave  jtag
);

    localparam logic [IR_WIDTH-1:0] c_ir_idcode  = IR_WIDTH'(IDCODE_IR);
    localparam logic [IR_WIDTH-1:0] c_ir_bypass  = IR_WIDTH'(bypass_opcode(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(1);

    tap_state_e w_state;

    logic [IR_WIDTH-1:0]       ir_q, ir_d;
    logic [IR_WIDTH-1:0]       ir_shift_q, ir_shift_d;
    logic [c_idcode_width-1:0] idcode_q, idcode_d;
    logic                      bypass_q, bypass_d;

    logic [NUM_USER_DR-1:0]    w_user_hit;
    logic [NUM_USER_DR-1:0]    w_dr_sel;
    logic                      w_sel_idcode;
    logic                      w_sel_bypass;
    logic                      w_td_o;

    jtag_tap_fsm u_fsm (
        .tck_i   (tck_i),
        .trst_i  (trst_i),
        .tms_i   (jtag.tms_i),
        .state_o (w_state)
    );

    generate
        for (genvar k = 0; k < NUM_USER_DR; k++) begin : g_dr_sel
            assign w_user_hit[k] = (ir_q == IR_WIDTH'(USER_IR_BASE + k));
        end
    endgenerate

    // All-ones always means BYPASS, even if a user range would overlap it
    assign w_sel_idcode = (ir_q == c_ir_idcode);
    assign w_dr_sel     = (w_sel_idcode || (ir_q == c_ir_bypass)) ? '0 : w_user_hit;
    assign w_sel_bypass = !w_sel_idcode && (w_dr_sel == '0);

    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;
        unique case (w_state)
            ST_CAP_IR:    ir_shift_d = c_ir_capture;
            ST_SHIFT_IR:  ir_shift_d = {jtag.td_i, ir_shift_q[IR_WIDTH-1:1]};
            ST_UPDATE_IR: ir_d = ir_shift_q;
            ST_CAP_DR: begin
                idcode_d = IDCODE_VAL;
                bypass_d = 1'b0;
            end
            ST_SHIFT_DR: begin
                if (w_sel_idcode) idcode_d = {jtag.td_i, idcode_q[c_idcode_width-1:1]};
                if (w_sel_bypass) bypass_d = jtag.td_i;
            end
            default: ;
        endcase
        // SEL_IR with tms high is the only arc into TLR; load IDCODE on that edge
        if ((w_state == ST_TLR) || ((w_state == ST_SEL_IR) && jtag.tms_i)) begin
            ir_d = c_ir_idcode;
        end
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            ir_q       <= c_ir_idcode;
            ir_shift_q <= '0;
            idcode_q   <= IDCODE_VAL;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        w_td_o = 1'b0;
        if (w_state == ST_SHIFT_IR) begin
            w_td_o = ir_shift_q[0];
        end else if (w_state == ST_SHIFT_DR) begin
            if (w_sel_idcode)      w_td_o = idcode_q[0];
            else if (w_sel_bypass) w_td_o = bypass_q;
            else                   w_td_o = |(w_dr_sel & jtag.user_tdo_i);
        end
    end

    assign jtag.td_o         = w_td_o;
    assign jtag.tdo_oe_o     = (w_state == ST_SHIFT_IR) || (w_state == ST_SHIFT_DR);
    assign jtag.ir_o         = ir_q;
    assign jtag.dr_sel_o     = w_dr_sel;
    assign jtag.capture_dr_o = (w_state == ST_CAP_DR);
    assign jtag.shift_dr_o   = (w_state == ST_SHIFT_DR);
    assign jtag.update_dr_o  = (w_state == ST_UPDATE_DR);
    assign jtag.state_o      = w_state;

endmodule
`default_nettype wire

// File: doc/jtag_tap_multi.md
Name: jtag_tap_multi

Overview:
Parametrised IEEE 1149.1-style TAP controller for the UAV RISC-V debug path. It is the successor to the fixed 5-bit-IR TAP. It adds:
- a configurable IR width,
- built-in IDCODE and BYPASS data registers,
- instruction decode to NUM_USER_DR external user data chains, with a one-hot select,
- a synchronous active-high reset.

It sits between the chip JTAG pins and the debug-module chains (DTM, DMI, and similar).

Parameters:
IR_WIDTH, 5, instruction register width (minimum 2)
NUM_USER_DR, 2, number of external user data-register chains (1..8)
USER_IR_BASE, 5'h10, opcode of user chain 0; chain k uses USER_IR_BASE+k
IDCODE_VAL, 32'h10E3_1913, IDCODE value (bit 0 must be 1)
IDCODE_IR, 5'h01, IDCODE opcode; also the reset instruction

Ports:
tck_i  in  1  TAP clock; all state updates on the rising edge
trst_i  in  1  synchronous active-high reset, sampled on rising tck_i
tms_i  in  1  test mode select
td_i  in  1  test data in
td_o  out  1  test data out (LSB of the active shift path)
tdo_oe_o  out  1  high only in SHIFT_DR or SHIFT_IR
ir_o  out  IR_WIDTH  current latched instruction
dr_sel_o  out  NUM_USER_DR  one-hot user chain select, decoded from ir_o
capture_dr_o  out  1  high while in CAPTURE_DR
shift_dr_o  out  1  high while in SHIFT_DR
update_dr_o  out  1  high while in UPDATE_DR
user_tdo_i  in  NUM_USER_DR  serial out of each user chain
state_o  out  4  current TAP state, for debug and bench

Behaviour:
- Reset (trst_i=1 at a rising edge):
  - state=TEST_LOGIC_RESET; ir_o=IDCODE_IR; IR shift register=0.
  - IDCODE shift register=IDCODE_VAL; bypass bit=0.
  - Reset dominates tms_i. Mid-shift reset aborts the shift with no update strobe.
- FSM: the full 16-state 1149.1 graph.
  - TLR -(0)-> RTI; TLR -(1)-> TLR.
  - RTI -(1)-> SEL_DR.
  - SEL_DR -(0)-> CAP_DR, -(1)-> SEL_IR.
  - SEL_IR -(0)-> CAP_IR, -(1)-> TLR.
  - CAP -(0)-> SHIFT, -(1)-> EXIT1.
  - SHIFT -(1)-> EXIT1.
  - EXIT1 -(0)-> PAUSE, -(1)-> UPDATE.
  - PAUSE -(1)-> EXIT2.
  - EXIT2 -(0)-> SHIFT, -(1)-> UPDATE.
  - UPDATE -(0)-> RTI, -(1)-> SEL_DR.
  - All other arcs self-loop.
  - From any state, 5 consecutive tms_i=1 edges reach TLR.
- Entering TLR by tms_i: ir_o is set to IDCODE_IR on the same edge.
- Strobes: capture/shift/update_dr_o are pure decodes of the state register (no extra latency). Each action takes effect on the rising edge that leaves the state.
- CAPTURE_IR: IR shift register loads {0…0,01}.
- SHIFT_IR: IR shift register shifts right; td_i enters at the MSB; td_o = shift LSB.
- UPDATE_IR: ir_o <= IR shift register on the edge leaving UPDATE_IR.
- Instruction decode:
  - ir_o==IDCODE_IR selects IDCODE.
  - ir_o in [USER_IR_BASE, USER_IR_BASE+NUM_USER_DR-1] sets dr_sel_o bit k.
  - Any other opcode, including all-ones, selects BYPASS; dr_sel_o=0.
- IDCODE register:
  - CAPTURE_DR reloads IDCODE_VAL.
  - SHIFT_DR shifts right with td_i in at bit 31.
  - td_o = bit 0.
- BYPASS: CAPTURE_DR clears the bit; SHIFT_DR loads td_i; td_o = bit. This gives exactly 1 cycle of delay.
- User chain k selected:
  - td_o = user_tdo_i[k].
  - The external chain uses capture/shift/update_dr_o qualified with dr_sel_o[k].
- td_o outside a shift state: 0, with tdo_oe_o=0.
- td_o path is combinational from registers only; it never depends combinationally on td_i.

Decomposition:
- Package jtag_tap_pkg:
  - tap_state_e (4-bit enum of the 16 states);
  - BYPASS opcode function (all ones for IR_WIDTH);
  - IDCODE width constant (32).
- Sub-module jtag_tap_fsm: the state register and next-state logic only. It has inputs tck_i, trst_i, tms_i and output state. The top level holds IR, DRs, decode and the td_o mux.

Test Plan:
- trst_i=1 for 2 edges, then 0 with tms_i=0 → state_o=TLR, then RTI; ir_o=5'h01; tdo_oe_o=0.
- From RTI, walk to SHIFT_DR and shift 32 bits of td_i=0 → td_o serial LSB-first = 32'h10E3_1913; tdo_oe_o=1 only during the 32 shift cycles.
- Load IR=5'h1F through SHIFT_IR/UPDATE_IR, then shift DR pattern 8'b1011_0010 → td_o shows the same pattern one cycle later, with first bit 0; dr_sel_o=0.
- Load IR=5'h11 → dr_sel_o=2'b10; td_o follows user_tdo_i[1]; capture/shift/update_dr_o each pulse for exactly one state visit.
- From SHIFT_IR, SHIFT_DR, PAUSE_DR and RTI, apply 5 tms_i=1 edges → state_o=TLR and ir_o=5'h01 each time.
- Assert trst_i mid SHIFT_DR after 10 bits → next edge state_o=TLR; update_dr_o never asserts; ir_o=5'h01.
